// File: rtl/wb_rr_arbiter_pkg.sv
// Shared state encoding, default watchdog limit and width helpers for wb_rr_arbiter.
package wb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Watchdog counter is kept between 8 and 16 bits wide.
    function automatic int wdog_width(input int timeout);
        int w;
        w = clog2(timeout + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Packed Wishbone master-side buses and the single slave-side port of wb_rr_arbiter.
interface wb_rr_arbiter_if #(
    parameter int NM    = 3,
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    localparam int SEL_W = DAT_W / 8;

    logic [NM*ADR_W-1:0] m_adr_i;
    logic [NM*DAT_W-1:0] m_dat_i;
    logic [NM*SEL_W-1:0] m_sel_i;
    logic [NM-1:0]       m_we_i;
    logic [NM-1:0]       m_cyc_i;
    logic [NM-1:0]       m_stb_i;
    logic [DAT_W-1:0]    m_dat_o;
    logic [NM-1:0]       m_ack_o;
    logic [NM-1:0]       m_err_o;
    logic [ADR_W-1:0]    s_adr_o;
    logic [DAT_W-1:0]    s_dat_o;
    logic [SEL_W-1:0]    s_sel_o;
    logic                s_we_o;
    logic                s_cyc_o;
    logic                s_stb_o;
    logic [DAT_W-1:0]    s_dat_i;
    logic                s_ack_i;

    // The arbiter is the slave of the masters and drives the conbus port.
    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping modulo NM.
module wb_rr_arbiter_rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter  int NM = 3,
    localparam int LW = clog2(NM)
) (
    input  logic [NM-1:0] req_i,
    input  logic [LW-1:0] last_i,
    output logic [NM-1:0] gnt_o,
    output logic          valid_o
);

    logic [LW-1:0] idx_s;

    // Scan from last+1; only the first requester seen gets the grant bit.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx_s   = '0;
        for (int off = 1; off <= NM; off++) begin
            idx_s        = LW'((int'(last_i) + off) % NM);
            gnt_o[idx_s] = req_i[idx_s] & ~valid_o;
            valid_o      = valid_o | req_i[idx_s];
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port of conbus among NM masters.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog and the ABORT state.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NM          = 3,
    parameter int ADR_W       = 32,
    parameter int DAT_W       = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    wb_rr_arbiter_if.slave bus,
    output logic [NM-1:0]  gnt_o
);

    localparam int LW    = clog2(NM);
    localparam int SEL_W = DAT_W / 8;

    arb_state_e       state_q, state_d;
    logic [NM-1:0]    gnt_q, gnt_d;
    logic [LW-1:0]    last_q, last_d;
    logic [LW-1:0]    g_idx_s, win_idx_s;
    logic [NM-1:0]    pick_gnt_s;
    logic             pick_valid_s;
    logic [ADR_W-1:0] s_adr_s;
    logic [DAT_W-1:0] s_dat_s, m_dat_s;
    logic [SEL_W-1:0] s_sel_s;
    logic             s_we_s, s_cyc_s, s_stb_s;
    logic [NM-1:0]    m_ack_s, m_err_s;

    wb_rr_arbiter_rr_pick #(.NM(NM)) u_pick (
        .req_i   (bus.m_cyc_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt_s),
        .valid_o (pick_valid_s)
    );

    // Binary index of the held grant and of the picker's winner (both one-hot).
    always_comb begin
        g_idx_s   = '0;
        win_idx_s = '0;
        for (int i = 0; i < NM; i++) begin
            g_idx_s   = g_idx_s   | (gnt_q[i]      ? LW'(i) : {LW{1'b0}});
            win_idx_s = win_idx_s | (pick_gnt_s[i] ? LW'(i) : {LW{1'b0}});
        end
    end

    // Only a live GRANT reaches the slave; IDLE and ABORT present an all-zero bus.
    always_comb begin
        s_adr_s = '0;
        s_dat_s = '0;
        s_sel_s = '0;
        s_we_s  = 1'b0;
        s_cyc_s = 1'b0;
        s_stb_s = 1'b0;
        m_ack_s = '0;
        m_dat_s = '0;
        case (state_q)
            ST_GRANT: begin
                s_adr_s          = bus.m_adr_i[g_idx_s*ADR_W +: ADR_W];
                s_dat_s          = bus.m_dat_i[g_idx_s*DAT_W +: DAT_W];
                s_sel_s          = bus.m_sel_i[g_idx_s*SEL_W +: SEL_W];
                s_we_s           = bus.m_we_i[g_idx_s];
                s_cyc_s          = bus.m_cyc_i[g_idx_s];
                s_stb_s          = bus.m_stb_i[g_idx_s];
                m_ack_s[g_idx_s] = bus.s_ack_i;
                m_dat_s          = bus.s_dat_i;
            end
            default: begin
                m_dat_s = '0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = wdog_width(TIMEOUT_CYC);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_hit_s;

    // The error fires on the stalled strobe cycle that would bring the count to TIMEOUT_CYC.
    assign timeout_hit_s = (state_q == ST_GRANT) && s_cyc_s && s_stb_s && !bus.s_ack_i &&
                           (wdog_q == WD_W'(TIMEOUT_CYC - 1));

    // Count stalled strobe cycles; an ack, abort or release restarts from zero.
    always_comb begin
        if ((state_d == ST_GRANT) && s_stb_s && !bus.s_ack_i) begin
            wdog_d = wdog_q + WD_W'(1);
        end else begin
            wdog_d = '0;
        end
    end

    // Watchdog count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // One-cycle error pulse to the granted master.
    always_comb begin
        m_err_s          = '0;
        m_err_s[g_idx_s] = timeout_hit_s;
    end
`else
    assign m_err_s = '0;
`endif

    // Arbitrate in IDLE, hold the grant for the whole bus cycle, release when cyc drops.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_gnt_s;
                    last_d  = win_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.m_cyc_i[g_idx_s]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit_s) begin
                    state_d = ST_ABORT;
`endif
                end else begin
                    state_d = ST_GRANT;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!bus.m_cyc_i[g_idx_s]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = ST_ABORT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers; master 0 wins first after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NM - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.s_adr_o = s_adr_s;
    assign bus.s_dat_o = s_dat_s;
    assign bus.s_sel_o = s_sel_s;
    assign bus.s_we_o  = s_we_s;
    assign bus.s_cyc_o = s_cyc_s;
    assign bus.s_stb_o = s_stb_s;
    assign bus.m_ack_o = m_ack_s;
    assign bus.m_dat_o = m_dat_s;
    assign bus.m_err_o = m_err_s;
    assign gnt_o       = gnt_q;

endmodule
